int_sub_rs: RTL and testbench

//  Reservation station and result stage for the integer subtract unit (int_sub) in the Tomasulo core.

---
 rtl/int_sub_rs.sv | 157 +++++++++++++++
 tb/tb_int_sub_rs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int_sub_rs.sv
// int_sub_rs: reservation station + result register for the int_sub unit.
// Holds SUB ops until operands arrive off the CDB, dispatches one per cycle.
//
// Ports:
//   clk, rst_n, flush         clocking, async reset, sync squash
//   iss_*                     issue request, free-entry tag, operands/tags
//   cdb_valid/tag/data        common data bus snoop
//   fu_a, fu_b / fu_res, fu_bout   operands to / result from int_sub
//   res_valid/ready/tag/data/bout  registered result toward CDB arbiter
//   busy                      per-entry occupied bitmap
module int_sub_rs #(
  parameter int XLEN    = 64,
  parameter int TAGW    = 4,
  parameter int NUM_RS  = 4,
  parameter int RS_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  output logic [TAGW-1:0]   iss_tag,
  input  logic [XLEN-1:0]   iss_vj,
  input  logic [TAGW-1:0]   iss_qj,
  input  logic              iss_qj_v,
  input  logic [XLEN-1:0]   iss_vk,
  input  logic [TAGW-1:0]   iss_qk,
  input  logic              iss_qk_v,
  input  logic              cdb_valid,
  input  logic [TAGW-1:0]   cdb_tag,
  input  logic [XLEN-1:0]   cdb_data,
  output logic [XLEN-1:0]   fu_a,
  output logic [XLEN-1:0]   fu_b,
  input  logic [XLEN-1:0]   fu_res,
  input  logic              fu_bout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAGW-1:0]   res_tag,
  output logic [XLEN-1:0]   res_data,
  output logic              res_bout,
  output logic [NUM_RS-1:0] busy
);

  localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0] wj_q;
  logic [NUM_RS-1:0] wk_q;
  logic [XLEN-1:0]   vj_q [NUM_RS];
  logic [XLEN-1:0]   vk_q [NUM_RS];
  logic [TAGW-1:0]   qj_q [NUM_RS];
  logic [TAGW-1:0]   qk_q [NUM_RS];

  logic [NUM_RS-1:0] rdy;
  logic [NUM_RS-1:0] iss_sel;
  logic [NUM_RS-1:0] disp_sel;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     disp_idx;
  logic              disp_en;
  logic              iss_do;
  logic              byp_j;
  logic              byp_k;

  assign rdy = busy & ~wj_q & ~wk_q;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
      if (rdy[i])   disp_idx = IW'(i);
    end
  end

  assign iss_ready = ~&busy;
  assign iss_tag   = TAGW'(RS_BASE) + TAGW'(free_idx);
  assign iss_do    = iss_valid & iss_ready;
  assign disp_en   = (|rdy) & (~res_valid | res_ready);

  always_comb begin
    iss_sel  = '0;
    disp_sel = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      iss_sel[i]  = iss_do & (free_idx == IW'(i));
      disp_sel[i] = disp_en & (disp_idx == IW'(i));
    end
  end

  assign fu_a = disp_en ? vj_q[disp_idx] : '0;
  assign fu_b = disp_en ? vk_q[disp_idx] : '0;

  // Operand arriving on the CDB in the issue cycle.
  assign byp_j = cdb_valid & iss_qj_v & (cdb_tag == iss_qj);
  assign byp_k = cdb_valid & iss_qk_v & (cdb_tag == iss_qk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      wj_q <= '0;
      wk_q <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      wj_q <= '0;
      wk_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (busy[i] && wj_q[i] && cdb_valid
            && qj_q[i] == cdb_tag) begin
          vj_q[i] <= cdb_data;
          wj_q[i] <= 1'b0;
        end
        if (busy[i] && wk_q[i] && cdb_valid
            && qk_q[i] == cdb_tag) begin
          vk_q[i] <= cdb_data;
          wk_q[i] <= 1'b0;
        end
        if (disp_sel[i]) busy[i] <= 1'b0;
        // Only free entries are selected, so this never
        // collides with the wakeup or dispatch above.
        if (iss_sel[i]) begin
          busy[i] <= 1'b1;
          qj_q[i] <= iss_qj;
          qk_q[i] <= iss_qk;
          wj_q[i] <= iss_qj_v & ~byp_j;
          wk_q[i] <= iss_qk_v & ~byp_k;
          vj_q[i] <= byp_j ? cdb_data : iss_vj;
          vk_q[i] <= byp_k ? cdb_data : iss_vk;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
      res_bout  <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (disp_en) begin
      res_valid <= 1'b1;
      res_tag   <= TAGW'(RS_BASE) + TAGW'(disp_idx);
      res_data  <= fu_res;
      res_bout  <= fu_bout;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_sub_rs.sv
// tb_int_sub_rs: directed bench for int_sub_rs.
// Models int_sub combinationally; checks hand-computed results.
module tb_int_sub_rs;

  localparam int XLEN = 64;
  localparam int TAGW = 4;
  localparam int NRS  = 4;

  logic            clk = 1'b0;
  logic            rst_n, flush;
  logic            iss_valid, iss_ready;
  logic [TAGW-1:0] iss_tag, iss_qj, iss_qk;
  logic [XLEN-1:0] iss_vj, iss_vk;
  logic            iss_qj_v, iss_qk_v;
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_data;
  logic [XLEN-1:0] fu_a, fu_b, fu_res;
  logic            fu_bout;
  logic            res_valid, res_ready, res_bout;
  logic [TAGW-1:0] res_tag;
  logic [XLEN-1:0] res_data;
  logic [NRS-1:0]  busy;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign fu_res  = fu_a - fu_b;
  assign fu_bout = (fu_a < fu_b);

  int_sub_rs #(.XLEN(XLEN), .TAGW(TAGW), .NUM_RS(NRS), .RS_BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .iss_vj(iss_vj), .iss_qj(iss_qj), .iss_qj_v(iss_qj_v),
    .iss_vk(iss_vk), .iss_qk(iss_qk), .iss_qk_v(iss_qk_v),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res), .fu_bout(fu_bout),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_bout(res_bout), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_vj = 0; iss_vk = 0;
    iss_qj = 0; iss_qk = 0; iss_qj_v = 0; iss_qk_v = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic drain();
    res_ready = 1;
    step();
    res_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; res_ready = 0;
    idle_inputs();
    repeat (3) step();
    nvec++; if (busy !== 4'b0) begin nmis++; $display("FAIL reset_busy got %0h exp 0", busy); end
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL reset_rv got %0b exp 0", res_valid); end
    nvec++; if (iss_ready !== 1'b1 || iss_tag !== 4'd0) begin nmis++; $display("FAIL reset_iss got %0b/%0d exp 1/0", iss_ready, iss_tag); end
    nvec++; if (res_data !== 64'd0 || res_tag !== 4'd0 || res_bout !== 1'b0) begin nmis++; $display("FAIL reset_res got %0h/%0d/%0b exp 0/0/0", res_data, res_tag, res_bout); end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    iss_valid = 1; iss_vj = 64'd20; iss_vk = 64'd4;
    step();
    idle_inputs();
    nvec++; if (busy !== 4'b0001) begin nmis++; $display("FAIL t1_busy got %0h exp 1", busy); end
    nvec++; if (fu_a !== 64'd20 || fu_b !== 64'd4) begin nmis++; $display("FAIL t1_fu got %0d/%0d exp 20/4", fu_a, fu_b); end
    step();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd16 || res_bout !== 1'b0 || res_tag !== 4'd0) begin nmis++; $display("FAIL t1_res got v%0b d%0d b%0b t%0d exp v1 d16 b0 t0", res_valid, res_data, res_bout, res_tag); end
    nvec++; if (busy !== 4'b0) begin nmis++; $display("FAIL t1_free got %0h exp 0", busy); end
    drain();
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL t1_drain got %0b exp 0", res_valid); end
  endtask

  task automatic test_borrow();
    iss_valid = 1; iss_vj = 64'd4; iss_vk = 64'd5;
    step();
    idle_inputs();
    step();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFF || res_bout !== 1'b1) begin nmis++; $display("FAIL t2_res got v%0b d%0h b%0b exp v1 dffffffffffffffff b1", res_valid, res_data, res_bout); end
    drain();
  endtask

  task automatic test_wakeup();
    iss_valid = 1; iss_qj_v = 1; iss_qj = 4'd7; iss_vk = 64'd1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL t3_wait%0d got %0b exp 0", i, res_valid); end
    end
    cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 64'd100;
    step();
    idle_inputs();
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL t3_early got %0b exp 0", res_valid); end
    step();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd99 || res_bout !== 1'b0) begin nmis++; $display("FAIL t3_res got v%0b d%0d b%0b exp v1 d99 b0", res_valid, res_data, res_bout); end
    drain();
  endtask

  task automatic test_fill_and_stall();
    logic [XLEN-1:0] exp_d;
    for (int i = 0; i < NRS; i++) begin
      iss_valid = 1; iss_qj_v = 1; iss_qj = 4'd9; iss_vk = 64'(i + 1);
      nvec++; if (iss_tag !== 4'(i)) begin nmis++; $display("FAIL t4_tag%0d got %0d exp %0d", i, iss_tag, i); end
      step();
    end
    nvec++; if (iss_ready !== 1'b0 || busy !== 4'b1111) begin nmis++; $display("FAIL t4_full got r%0b b%0h exp r0 bf", iss_ready, busy); end
    iss_vk = 64'd77; iss_qj_v = 0;
    step();
    idle_inputs();
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 64'd50;
    step();
    idle_inputs();
    nvec++; if (res_valid !== 1'b0) begin nmis++; $display("FAIL t4_early got %0b exp 0", res_valid); end
    step();
    for (int c = 0; c < 3; c++) begin
      nvec++; if (res_valid !== 1'b1 || res_data !== 64'd49 || res_tag !== 4'd0 || busy !== 4'b1110) begin nmis++; $display("FAIL t4_hold%0d got v%0b d%0d t%0d b%0h exp v1 d49 t0 be", c, res_valid, res_data, res_tag, busy); end
      step();
    end
    res_ready = 1;
    for (int i = 1; i < NRS; i++) begin
      step();
      exp_d = 64'(50 - (i + 1));
      nvec++; if (res_valid !== 1'b1 || res_data !== exp_d || res_tag !== 4'(i)) begin nmis++; $display("FAIL t4_seq%0d got v%0b d%0d t%0d exp v1 d%0d t%0d", i, res_valid, res_data, res_tag, exp_d, i); end
    end
    step();
    res_ready = 0;
    nvec++; if (res_valid !== 1'b0 || busy !== 4'b0) begin nmis++; $display("FAIL t4_empty got v%0b b%0h exp v0 b0", res_valid, busy); end
  endtask

  task automatic test_bypass();
    iss_valid = 1; iss_vj = 64'd30; iss_qk_v = 1; iss_qk = 4'd5;
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 64'd12;
    step();
    idle_inputs();
    step();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd18) begin nmis++; $display("FAIL t5_k got v%0b d%0d exp v1 d18", res_valid, res_data); end
    drain();
    iss_valid = 1; iss_qj_v = 1; iss_qj = 4'd6; iss_qk_v = 1; iss_qk = 4'd6;
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 64'd7;
    step();
    idle_inputs();
    step();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd0 || res_bout !== 1'b0) begin nmis++; $display("FAIL t5_jk got v%0b d%0d b%0b exp v1 d0 b0", res_valid, res_data, res_bout); end
    drain();
  endtask

  task automatic setup_busy();
    iss_valid = 1; iss_vj = 64'd9; iss_vk = 64'd3;
    step();
    iss_vj = 0; iss_vk = 0; iss_qj_v = 1; iss_qj = 4'd9;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_flush();
    setup_busy();
    nvec++; if (res_valid !== 1'b1 || res_data !== 64'd6 || busy !== 4'b0010) begin nmis++; $display("FAIL t6_setup got v%0b d%0d b%0h exp v1 d6 b2", res_valid, res_data, busy); end
    #2 rst_n = 0;
    #1;
    nvec++; if (busy !== 4'b0 || res_valid !== 1'b0 || iss_ready !== 1'b1 || res_data !== 64'd0) begin nmis++; $display("FAIL t6_arst got b%0h v%0b r%0b d%0d exp b0 v0 r1 d0", busy, res_valid, iss_ready, res_data); end
    #1 rst_n = 1;
    step();
    setup_busy();
    flush = 1;
    step();
    flush = 0;
    nvec++; if (busy !== 4'b0 || res_valid !== 1'b0 || iss_ready !== 1'b1 || iss_tag !== 4'd0) begin nmis++; $display("FAIL t6_flush got b%0h v%0b r%0b t%0d exp b0 v0 r1 t0", busy, res_valid, iss_ready, iss_tag); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_wakeup();
    test_fill_and_stall();
    test_bypass();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
